inst_fetch_queue: RTL and testbench

Prefetch queue between the word-wide instruction ROM and the CPU decode logic. Issues word-aligned ROM reads ahead of execution, buffers the returned bytes in a circular byte queue, and presents the next 6 bytes at the current PC so decode can extract a variable-length Y86 instruction (1–6 bytes). Control-flow redirects from the CPU flush the queue and restart fetching at any byte address.

---
 rtl/inst_fetch_queue_pkg.sv | 15 +
 rtl/inst_fetch_queue_fetch_byte_ring.sv | 39 +++
 rtl/inst_fetch_queue.sv | 93 +++++++++
 tb/tb_inst_fetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared sizes and helpers for the instruction prefetch queue
package inst_fetch_queue_pkg;

  localparam int WORD            = 32;
  localparam int INSTBUS         = 48;
  localparam int INST_BYTES      = 6;
  localparam int DEPTH_BYTES_DEF = 16;

  typedef logic [7:0] byte_t;

  function automatic logic len_legal(input logic [2:0] len);
    return (len != 3'd0) && (len <= 3'(INST_BYTES));
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_byte_ring.sv
// rtl/inst_fetch_queue_fetch_byte_ring.sv - byte ring with a 4-byte write port and a 6-byte read window
module fetch_byte_ring
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_BYTES)-1:0] wr_ptr,
  input  logic [1:0]                     wr_skip,
  input  logic [WORD-1:0]                wr_data,
  input  logic [$clog2(DEPTH_BYTES)-1:0] rd_ptr,
  output logic [INSTBUS-1:0]             rd_window
);

  localparam int PW = $clog2(DEPTH_BYTES);

  byte_t mem [DEPTH_BYTES];

  // Leading wr_skip bytes of the word are dropped; the rest pack from wr_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (j >= int'(wr_skip))
          mem[wr_ptr + PW'(j - int'(wr_skip))] <= wr_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    rd_window = '0;
    for (int k = 0; k < INST_BYTES; k++)
      rd_window[INSTBUS-1-8*k -: 8] = mem[rd_ptr + PW'(k)];
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - word-wide ROM prefetch into a byte queue presenting 6 bytes at the PC
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rom_rd_o,
  output logic [WORD-1:0]    rom_addr_o,
  input  logic [WORD-1:0]    rom_data_i,
  input  logic               redirect_i,
  input  logic [WORD-1:0]    redirect_pc_i,
  input  logic               consume_i,
  input  logic [2:0]         consume_len_i,
  output logic [INSTBUS-1:0] inst_o,
  output logic               inst_valid_o,
  output logic [WORD-1:0]    pc_o
);

  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [WORD-1:0] fetch_addr, pc;
  logic            inflight;
  logic [1:0]      skip;

  logic            cons_ok, accept, issue;
  logic [CW-1:0]   cons_len, acc_len;
  logic [SW-1:0]   space_need;

  // The word returning this cycle is counted as occupied so a new request
  // can overlap it without ever overflowing the ring.
  always_comb begin
    inst_valid_o = (count >= CW'(INST_BYTES));
    cons_ok      = consume_i && inst_valid_o && len_legal(consume_len_i) && !redirect_i;
    cons_len     = cons_ok ? CW'(consume_len_i) : '0;
    accept       = inflight && !redirect_i;
    acc_len      = accept ? CW'(3'd4 - {1'b0, skip}) : '0;
    space_need   = SW'(count) + SW'(acc_len) + SW'(4) - SW'(cons_len);
    issue        = !rst && !redirect_i && (space_need <= SW'(DEPTH_BYTES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_addr <= '0;
      pc         <= '0;
      inflight   <= 1'b0;
      skip       <= '0;
    end else if (redirect_i) begin
      // Clearing inflight kills any response that would have landed.
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pc         <= redirect_pc_i;
      fetch_addr <= {redirect_pc_i[WORD-1:2], 2'b00};
      skip       <= redirect_pc_i[1:0];
      inflight   <= 1'b0;
    end else begin
      head     <= head + PW'(cons_len);
      tail     <= tail + PW'(acc_len);
      count    <= count - cons_len + acc_len;
      pc       <= pc + WORD'(cons_len);
      inflight <= issue;
      if (accept) skip <= '0;
      if (issue) fetch_addr <= fetch_addr + 32'd4;
    end
  end

  assign rom_rd_o   = issue;
  assign rom_addr_o = fetch_addr;
  assign pc_o       = pc;

  fetch_byte_ring #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_ptr    (tail),
    .wr_skip   (skip),
    .wr_data   (rom_data_i),
    .rd_ptr    (head),
    .rd_window (inst_o)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_rd_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        consume_i;
  logic [2:0]  consume_len_i;
  logic [47:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH_BYTES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_rd_o      (rom_rd_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .consume_i     (consume_i),
    .consume_len_i (consume_len_i),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .pc_o          (pc_o)
  );

  // ROM: byte at address a holds a[7:0]; data returns the cycle after the request.
  always @(posedge clk) begin
    if (rom_rd_o)
      rom_data_i <= {8'(rom_addr_o + 32'd3), 8'(rom_addr_o + 32'd2),
                     8'(rom_addr_o + 32'd1), 8'(rom_addr_o)};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] window(input logic [31:0] a);
    logic [47:0] w;
    for (int k = 0; k < 6; k++) w[47-8*k -: 8] = 8'(a + 32'(k));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!inst_valid_o && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(inst_valid_o), 64'd1);
  endtask

  int          lens [5] = '{1, 2, 3, 5, 6};
  logic [31:0] exp_pc;
  int          idx;

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    consume_i = 1'b0; consume_len_i = '0; rom_data_i = '0;
    tick(); tick();
    check("rst_rd",    64'(rom_rd_o),     64'd0);
    check("rst_addr",  64'(rom_addr_o),   64'd0);
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_pc",    64'(pc_o),         64'd0);
    check("rst_inst",  64'(inst_o),       64'd0);

    // start-up latency
    rst = 1'b0; #1;
    check("n0_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h0}));
    tick();
    check("n1_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h4}));
    check("n1_valid", 64'(inst_valid_o), 64'd0);
    tick();
    check("n2_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h8}));
    check("n2_valid", 64'(inst_valid_o), 64'd0);
    tick();
    check("n3_valid", 64'(inst_valid_o), 64'd1);
    check("n3_inst",  64'(inst_o), 64'(48'h000102030405));
    check("n3_pc",    64'(pc_o), 64'd0);
    check("n3_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'hc}));
    tick();
    check("n4_stall", 64'(rom_rd_o), 64'd0);
    tick(); tick();
    check("full_stall", 64'(rom_rd_o), 64'd0);
    check("full_inst",  64'(inst_o), 64'(48'h000102030405));

    // walking consume across ring wrap
    exp_pc = 32'h0;
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      if (inst_valid_o) begin
        check("walk_pc",   64'(pc_o),   64'(exp_pc));
        check("walk_inst", 64'(inst_o), 64'(window(exp_pc)));
        consume_i = 1'b1;
        consume_len_i = 3'(lens[idx % 5]);
        exp_pc = exp_pc + 32'(lens[idx % 5]);
        idx++;
      end else begin
        consume_i = 1'b0;
      end
      tick();
    end
    consume_i = 1'b0; #1;
    check("walk_progress", 64'(idx >= 30), 64'd1);
    wait_valid("walk_end_valid", 10);
    check("walk_end_pc", 64'(pc_o), 64'(exp_pc));

    // illegal lengths are ignored
    consume_i = 1'b1; consume_len_i = 3'd0; tick();
    check("len0_pc", 64'(pc_o), 64'(exp_pc));
    consume_len_i = 3'd7; tick();
    check("len7_pc",   64'(pc_o),   64'(exp_pc));
    check("len7_inst", 64'(inst_o), 64'(window(exp_pc)));
    consume_i = 1'b0;

    // redirect to an unaligned target
    redirect_i = 1'b1; redirect_pc_i = 32'h13; #1;
    check("redir_noissue", 64'(rom_rd_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    consume_i = 1'b1; consume_len_i = 3'd1; #1;
    check("r1_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h10}));
    check("r1_pc",    64'(pc_o), 64'h13);
    check("r1_valid", 64'(inst_valid_o), 64'd0);
    tick();
    consume_i = 1'b0; #1;
    check("r2_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h14}));
    check("r2_pc",    64'(pc_o), 64'h13);
    tick();
    check("r3_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h18}));
    check("r3_valid", 64'(inst_valid_o), 64'd0);
    tick();
    check("r4_valid", 64'(inst_valid_o), 64'd0);
    tick();
    check("r5_valid", 64'(inst_valid_o), 64'd1);
    check("r5_inst",  64'(inst_o), 64'(48'h131415161718));
    check("r5_pc",    64'(pc_o), 64'h13);

    // redirect in the cycle a response returns, with a consume
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    consume_i = 1'b1; consume_len_i = 3'd2; #1;
    check("rr_noissue", 64'(rom_rd_o), 64'd0);
    tick();
    redirect_i = 1'b0; consume_i = 1'b0; #1;
    check("rr_pc",    64'(pc_o), 64'h40);
    check("rr_valid", 64'(inst_valid_o), 64'd0);
    check("rr_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h40}));
    wait_valid("rr_refill_valid", 10);
    check("rr_inst", 64'(inst_o), 64'(window(32'h40)));
    check("rr_pc2",  64'(pc_o), 64'h40);

    // reset while full with a request in flight
    tick(); tick(); tick(); tick();
    check("full2_stall", 64'(rom_rd_o), 64'd0);
    consume_i = 1'b1; consume_len_i = 3'd4; #1;
    check("free_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h50}));
    tick();
    consume_i = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_rd",    64'(rom_rd_o),     64'd0);
    check("mid_rst_addr",  64'(rom_addr_o),   64'd0);
    check("mid_rst_valid", 64'(inst_valid_o), 64'd0);
    check("mid_rst_pc",    64'(pc_o),         64'd0);
    check("mid_rst_inst",  64'(inst_o),       64'd0);
    rst = 1'b0; #1;
    check("post_rst_issue", 64'({rom_rd_o, rom_addr_o}), 64'({1'b1, 32'h0}));
    wait_valid("post_rst_valid", 10);
    check("post_rst_inst", 64'(inst_o), 64'(48'h000102030405));
    check("post_rst_pc",   64'(pc_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
